// File: rtl/cache_ctrl_if.sv
// Bus bundle between the cache controller and its environment: the CPU
// request port, the external tag/data RAMs and the main-memory port.
// "master" is the environment side (CPU, RAMs, memory); "slave" is the
// controller itself.
interface cache_ctrl_if #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
);
  localparam int ADDR_W = TAG_W + INDEX_W;

  // CPU side
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic               cpu_ready;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               busy;

  // Tag RAM
  logic               tag_write;
  logic [INDEX_W-1:0] tag_index;
  logic [TAG_W-1:0]   tag_wr;
  logic [TAG_W-1:0]   tag_rd;

  // Data RAM
  logic               data_write;
  logic [INDEX_W-1:0] data_index;
  logic [DATA_W-1:0]  data_wdata;
  logic [DATA_W-1:0]  data_rdata;

  // Main memory
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ack;
  logic [DATA_W-1:0]  mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output tag_rd, data_rdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, busy,
    input  tag_write, tag_index, tag_wr,
    input  data_write, data_index, data_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  tag_rd, data_rdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, busy,
    output tag_write, tag_index, tag_wr,
    output data_write, data_index, data_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for the direct-mapped, single-word-line cache of the
// MIPS core. Owns the per-line valid bits, drives the external tag/data RAMs
// (registered reads, one-cycle latency), refills from main memory on a read
// miss and handles writes as write-through without allocation.
module cache_ctrl #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input logic         clock,
  input logic         reset,
  cache_ctrl_if.slave bus
);
  localparam int ADDR_W = TAG_W + INDEX_W;
  localparam int LINES  = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    CMP    = 3'd2,
    MEM_RD = 3'd3,
    FILL   = 3'd4,
    MEM_WR = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Request captured at acceptance; everything after IDLE works from these.
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  fill_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [LINES-1:0]   valid;

  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic               hit;

  logic               ready_c;
  logic [DATA_W-1:0]  rdata_c;
  logic               tag_write_c;
  logic               data_write_c;
  logic [DATA_W-1:0]  data_wdata_c;
  logic               mem_req_c;
  logic               mem_we_c;

  assign index_q = addr_q[INDEX_W-1:0];
  assign tag_q   = addr_q[ADDR_W-1:INDEX_W];

  // The RAM read data is only meaningful in CMP, where it reflects index_q.
  assign hit = valid[index_q] && (bus.tag_rd == tag_q);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: new requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.cpu_req) state_next = READ;
      READ:    state_next = CMP;
      CMP: begin
        if (we_q)     state_next = MEM_WR;
        else if (hit) state_next = IDLE;
        else          state_next = MEM_RD;
      end
      MEM_RD:  if (bus.mem_ack) state_next = FILL;
      FILL:    state_next = IDLE;
      MEM_WR:  if (bus.mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state outputs; RAM writes only happen in CMP (write hit) or FILL.
  always_comb begin
    ready_c      = 1'b0;
    rdata_c      = rdata_q;
    tag_write_c  = 1'b0;
    data_write_c = 1'b0;
    data_wdata_c = wdata_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    unique case (state)
      CMP: begin
        if (hit) begin
          if (we_q) begin
            data_write_c = 1'b1;
            data_wdata_c = wdata_q;
          end else begin
            ready_c = 1'b1;
            rdata_c = bus.data_rdata;
          end
        end
      end
      MEM_RD: begin
        mem_req_c = 1'b1;
      end
      FILL: begin
        tag_write_c  = 1'b1;
        data_write_c = 1'b1;
        data_wdata_c = fill_q;
        ready_c      = 1'b1;
        rdata_c      = fill_q;
      end
      MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        ready_c   = bus.mem_ack;
      end
      default: begin
      end
    endcase
  end

  // Request latch, refill capture, valid bits and the held read-data word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
      valid   <= '0;
    end else begin
      if (state == IDLE && bus.cpu_req) begin
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
      if (state == MEM_RD && bus.mem_ack) begin
        fill_q <= bus.mem_rdata;
      end
      if (state == FILL) begin
        valid[index_q] <= 1'b1;
      end
      if (ready_c) begin
        rdata_q <= rdata_c;
      end
    end
  end

  assign bus.cpu_ready  = ready_c;
  assign bus.cpu_rdata  = rdata_c;
  assign bus.busy       = (state != IDLE);
  assign bus.tag_write  = tag_write_c;
  assign bus.tag_index  = index_q;
  assign bus.tag_wr     = tag_q;
  assign bus.data_write = data_write_c;
  assign bus.data_index = index_q;
  assign bus.data_wdata = data_wdata_c;
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural tag/data RAMs and main memory around the
// controller, directed scenarios followed by random traffic, with expected
// hit/miss, data and RAM/memory activity taken from a line-level cache model.
module tb_cache_ctrl;
  localparam int INDEX_W = 10;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = TAG_W + INDEX_W;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  cache_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cache_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // External RAMs as seen by the controller
  logic [TAG_W-1:0]  tag_ram  [0:(2**INDEX_W)-1];
  logic [DATA_W-1:0] data_ram [0:(2**INDEX_W)-1];

  // Reference: main memory contents plus which tag each line holds
  logic [DATA_W-1:0] mmem   [0:(2**ADDR_W)-1];
  logic              mvalid [0:(2**INDEX_W)-1];
  logic [TAG_W-1:0]  mtag   [0:(2**INDEX_W)-1];
  logic [DATA_W-1:0] last_rd;

  int compared   = 0;
  int mismatched = 0;

  // Registered-read RAMs, written on the clock edge
  always @(posedge clock) begin
    if (bus.tag_write) tag_ram[bus.tag_index] <= bus.tag_wr;
    if (bus.data_write) data_ram[bus.data_index] <= bus.data_wdata;
    bus.tag_rd     <= tag_ram[bus.tag_index];
    bus.data_rdata <= data_ram[bus.data_index];
  end

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One CPU transaction, with memory answering after ack_delay wait cycles
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input int ack_delay);
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] idx;
    logic               exp_hit;
    logic [DATA_W-1:0]  exp_word;
    logic [DATA_W-1:0]  got;
    logic               done;
    logic               saw_mem;
    logic               pending;
    int cyc;
    int ready_cyc;
    int ack_cyc;
    int delay;
    int n_tw;
    int n_dw;
    tag      = addr[ADDR_W-1:INDEX_W];
    idx      = addr[INDEX_W-1:0];
    exp_hit  = mvalid[idx] && (mtag[idx] == tag);
    exp_word = we ? wdata : mmem[addr];
    got = '0; done = 1'b0; saw_mem = 1'b0; pending = 1'b0;
    cyc = 0; ready_cyc = -1; ack_cyc = -10; delay = 0; n_tw = 0; n_dw = 0;

    checkOutput("idle_before", bus.busy, 1'b0);
    @(posedge clock); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;

    while (!done && cyc < 40) begin
      @(posedge clock); #1;
      bus.cpu_req = 1'b0;
      bus.mem_ack = 1'b0;
      if (cyc == 0) begin
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = ADDR_W'($urandom);
        bus.cpu_wdata = $urandom;
      end
      if (pending) begin
        if (delay == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mmem[addr];
          pending       = 1'b0;
          ack_cyc       = cyc + 1;
        end else begin
          delay--;
          bus.cpu_req   = 1'($urandom);
          bus.mem_rdata = $urandom;
        end
      end
      @(negedge clock);
      cyc++;
      if (cyc == 1) checkOutput("busy_after_accept", bus.busy, 1'b1);
      if (bus.tag_write) begin
        n_tw++;
        checkOutput("tag_wr", bus.tag_wr, tag);
        checkOutput("tag_index", bus.tag_index, idx);
      end
      if (bus.data_write) begin
        n_dw++;
        checkOutput("data_wdata", bus.data_wdata, exp_word);
        checkOutput("data_index", bus.data_index, idx);
      end
      if (bus.mem_req && !saw_mem) begin
        saw_mem = 1'b1;
        pending = 1'b1;
        delay   = ack_delay;
        checkOutput("mem_addr", bus.mem_addr, addr);
        checkOutput("mem_we", bus.mem_we, we);
        if (we) checkOutput("mem_wdata", bus.mem_wdata, wdata);
      end
      if (cyc == ack_cyc + 1) checkOutput("mem_req_drop", bus.mem_req, 1'b0);
      if (bus.cpu_ready) begin
        done      = 1'b1;
        ready_cyc = cyc;
        got       = bus.cpu_rdata;
      end
    end

    checkOutput("ready_seen", done, 1'b1);
    if (!we) checkOutput("rdata", got, exp_word);
    if (!we && exp_hit) checkOutput("hit_latency", ready_cyc, 2);
    checkOutput("mem_used", saw_mem, !(!we && exp_hit));
    checkOutput("tag_writes", n_tw, (!we && !exp_hit) ? 1 : 0);
    checkOutput("data_writes", n_dw, ((!we && !exp_hit) || (we && exp_hit)) ? 1 : 0);

    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clock);
    if (!we) last_rd = exp_word;
    checkOutput("idle_after", bus.busy, 1'b0);
    checkOutput("single_ready", bus.cpu_ready, 1'b0);
    checkOutput("mem_req_idle", bus.mem_req, 1'b0);
    checkOutput("rdata_hold", bus.cpu_rdata, last_rd);

    if (!we && !exp_hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
    end
    if (we) mmem[addr] = wdata;
  endtask

  // Stray acknowledge while idle must not start anything
  task automatic strayAck();
    @(posedge clock); #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    @(negedge clock);
    checkOutput("stray_ready", bus.cpu_ready, 1'b0);
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    @(negedge clock);
    checkOutput("stray_busy", bus.busy, 1'b0);
    checkOutput("stray_mem_req", bus.mem_req, 1'b0);
  endtask

  // Reset asserted mid-cycle while waiting on a memory read
  task automatic resetMidRead(input logic [ADDR_W-1:0] addr);
    int cnt;
    @(posedge clock); #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    @(posedge clock); #1;
    bus.cpu_req = 1'b0;
    cnt = 0;
    while (!bus.mem_req && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("rst_reached_mem_rd", bus.mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mem_req_drop", bus.mem_req, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_ready", bus.cpu_ready, 1'b0);
    repeat (2) begin
      @(negedge clock);
      checkOutput("rst_hold_ready", bus.cpu_ready, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 2**INDEX_W; i++) mvalid[i] = 1'b0;
    last_rd = '0;
    @(negedge clock);
    checkOutput("rst_release_ready", bus.cpu_ready, 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    for (int i = 0; i < 2**INDEX_W; i++) begin
      tag_ram[i]  = '0;
      data_ram[i] = '0;
      mvalid[i]   = 1'b0;
      mtag[i]     = '0;
    end
    for (int i = 0; i < 2**ADDR_W; i++) mmem[i] = $urandom;
    mmem[14'h0005] = 32'hDEADBEEF;
    mmem[14'h0405] = 32'h0BADF00D;
    last_rd = '0;

    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_ready", bus.cpu_ready, 1'b0);
    checkOutput("reset_mem_req", bus.mem_req, 1'b0);
    checkOutput("reset_mem_we", bus.mem_we, 1'b0);
    checkOutput("reset_tag_write", bus.tag_write, 1'b0);
    checkOutput("reset_data_write", bus.data_write, 1'b0);
    checkOutput("reset_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("reset_mem_addr", bus.mem_addr, 14'h0);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(1'b0, 14'h0005, 32'h0, 3);
    applyStimulus(1'b0, 14'h0005, 32'h0, 0);
    applyStimulus(1'b0, 14'h0405, 32'h0, 2);
    applyStimulus(1'b0, 14'h0005, 32'h0, 1);
    applyStimulus(1'b0, 14'h0405, 32'h0, 0);
    applyStimulus(1'b1, 14'h0405, 32'h12345678, 2);
    applyStimulus(1'b0, 14'h0405, 32'h0, 0);
    applyStimulus(1'b1, 14'h2007, 32'hCAFE0007, 1);
    applyStimulus(1'b0, 14'h2007, 32'h0, 1);

    strayAck();
    resetMidRead(14'h0123);
    applyStimulus(1'b0, 14'h0005, 32'h0, 1);

    for (int n = 0; n < 200; n++) begin
      logic [ADDR_W-1:0] a;
      a = {TAG_W'($urandom_range(0, 3)), INDEX_W'($urandom_range(0, 7))};
      applyStimulus(($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 3));
      if (n % 50 == 25) strayAck();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the direct-mapped, single-word-line instruction/data cache in the MIPS core.
- Accepts word requests from the CPU side and drives the external tag RAM and data RAM. Both RAMs read on the clock edge with one-cycle latency.
- Holds the per-line valid bits. Refills from main memory on a read miss; writes are write-through with no write-allocate.

Parameters:
- INDEX_W, 10, line index width; number of lines = 2**INDEX_W (1024).
- TAG_W, 4, tag width.
- DATA_W, 32, word width.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears state, outputs and all valid bits.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  TAG_W+INDEX_W  word address {tag, index}.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready is high, held until the next completion.
- busy  out  1  high whenever state != IDLE.
- tag_write  out  1  tag RAM write enable.
- tag_index  out  INDEX_W  tag RAM index.
- tag_wr  out  TAG_W  tag RAM write data.
- tag_rd  in  TAG_W  tag RAM read data (registered in the RAM).
- data_write  out  1  data RAM write enable.
- data_index  out  INDEX_W  data RAM index.
- data_wdata  out  DATA_W  data RAM write data.
- data_rdata  in  DATA_W  data RAM read data (registered in the RAM).
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  TAG_W+INDEX_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle memory completion.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset values: state = IDLE; all valid bits = 0; cpu_ready, busy, tag_write, data_write, mem_req, mem_we = 0; cpu_rdata, mem_addr, mem_wdata = 0.
- Reset taking effect mid-transaction drops mem_req immediately and abandons the transaction. No cpu_ready pulse is issued for it.
- Request latch: when cpu_req=1 in IDLE, register cpu_we, cpu_addr and cpu_wdata, then go to READ.
  - All later outputs derive from these latched values only.
  - cpu_req while busy is ignored.
- tag_index and data_index always equal the latched index.
- READ: present the index; the RAMs capture on the edge ending this cycle. Next state is CMP.
- CMP: hit = valid[index] and (tag_rd == latched tag).
  - Read hit: cpu_ready=1 and cpu_rdata=data_rdata this cycle, then IDLE. Total latency: 2 cycles after the acceptance edge.
  - Read miss: go to MEM_RD.
  - Write hit: data_write=1 with data_wdata=wdata this cycle, then go to MEM_WR.
  - Write miss: go to MEM_WR with no RAM write.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched address, held until mem_ack.
  - On mem_ack, capture mem_rdata and go to FILL.
- FILL (exactly one cycle):
  - tag_write=1 with tag_wr=latched tag.
  - data_write=1 with data_wdata=captured word.
  - valid[index] set to 1.
  - cpu_ready=1 with cpu_rdata=captured word.
  - Next state is IDLE.
- MEM_WR: mem_req=1, mem_we=1, mem_addr=latched address, mem_wdata=latched wdata, held until mem_ack.
  - On mem_ack: cpu_ready=1 (cpu_rdata unchanged), then IDLE.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- mem_req deasserts in the cycle after mem_ack.
- At most one of tag_write/data_write sequences is active per transaction. No RAM write occurs in IDLE or READ.
- A conflict refill overwrites the tag; the old line is dropped silently (write-through, so no writeback).

Test Plan:
1. After reset, read 14'h0005 -> miss; mem_req with mem_addr 14'h0005; bench acks after 3 cycles with 32'hDEADBEEF -> FILL writes tag 0 at index 5; cpu_ready with 32'hDEADBEEF.
2. Read 14'h0005 again -> hit; no mem_req; cpu_ready 2 cycles after acceptance with 32'hDEADBEEF.
3. Read 14'h0405 (tag 1, index 5) -> conflict miss; refill with 32'h0BADF00D writes tag 1; a following read of 14'h0005 misses again.
4. Write 14'h0405 = 32'h12345678 (hit) -> data_write in CMP; mem write with that data; cpu_ready after ack; read 14'h0405 then hits with 32'h12345678.
5. Write 14'h2007 (miss) -> memory write only, no tag_write/data_write; a subsequent read of 14'h2007 misses.
6. Assert reset while in MEM_RD -> mem_req low asynchronously and no cpu_ready; after release, read 14'h0005 misses. Also: cpu_req pulses during busy and stray mem_ack in IDLE cause no state change.
